// File: rtl/pll_cfg_seq.sv
// rtl/pll_cfg_seq.sv - PLL reset/divider configuration and lock qualification sequencer
module pll_cfg_seq #(
   parameter int REF_DEV_WIDTH = 4,
   parameter int FB_DIV_WIDTH  = 8,
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_STABLE   = 8,
   parameter int LOCK_TIMEOUT  = 65535
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [REF_DEV_WIDTH-1:0] req_refdiv_i,
   input  logic [FB_DIV_WIDTH-1:0]  req_fbdiv_i,
   output logic                     pll_arst_no,
   output logic [REF_DEV_WIDTH-1:0] pll_refdiv_o,
   output logic [FB_DIV_WIDTH-1:0]  pll_fbdiv_o,
   input  logic                     pll_locked_i,
   output logic                     busy_o,
   output logic                     locked_o,
   output logic                     lost_lock_o,
   output logic                     error_o
);
   localparam int RC_W = $clog2(RST_CYCLES) + 1;
   localparam int ST_W = $clog2(LOCK_STABLE) + 1;
   localparam int TO_W = $clog2(LOCK_TIMEOUT) + 1;
   localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOCK_STABLE - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET,
      ST_WAIT_LOCK,
      ST_LOCKED,
      ST_ERROR
   } state_t;

   state_t                   state_q;
   logic                     sync1_q, sync2_q;
   logic [RC_W-1:0]          rst_cnt_q;
   logic [ST_W-1:0]          stb_cnt_q;
   logic [TO_W-1:0]          to_cnt_q;
   logic                     arst_n_q, locked_q, lost_q, error_q;
   logic [REF_DEV_WIDTH-1:0] refdiv_q;
   logic [FB_DIV_WIDTH-1:0]  fbdiv_q;

   logic lock_s, accept, div_zero;

   assign lock_s      = sync2_q;
   assign req_ready_o = (state_q == ST_IDLE) | (state_q == ST_LOCKED) | (state_q == ST_ERROR);
   assign busy_o      = (state_q == ST_RESET) | (state_q == ST_WAIT_LOCK);
   assign accept      = req_valid_i & req_ready_o & ~rst_i;
   assign div_zero    = (req_refdiv_i == '0) | (req_fbdiv_i == '0);

   assign pll_arst_no  = arst_n_q;
   assign pll_refdiv_o = refdiv_q;
   assign pll_fbdiv_o  = fbdiv_q;
   assign locked_o     = locked_q;
   assign lost_lock_o  = lost_q;
   assign error_o      = error_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         rst_cnt_q <= '0;
         stb_cnt_q <= '0;
         to_cnt_q  <= '0;
         arst_n_q  <= 1'b0;
         locked_q  <= 1'b0;
         lost_q    <= 1'b0;
         error_q   <= 1'b0;
         refdiv_q  <= '0;
         fbdiv_q   <= '0;
      end else begin
         sync1_q <= pll_locked_i;
         sync2_q <= sync1_q;
         lost_q  <= 1'b0;
         // An accepted request overrides whatever the current state would do, including a lock drop.
         if (accept) begin
            arst_n_q <= 1'b0;
            locked_q <= 1'b0;
            if (div_zero) begin
               state_q <= ST_ERROR;
               error_q <= 1'b1;
            end else begin
               state_q   <= ST_RESET;
               error_q   <= 1'b0;
               refdiv_q  <= req_refdiv_i;
               fbdiv_q   <= req_fbdiv_i;
               rst_cnt_q <= RC_LOAD;
            end
         end else begin
            case (state_q)
               ST_RESET: begin
                  if (rst_cnt_q == '0) begin
                     arst_n_q  <= 1'b1;
                     state_q   <= ST_WAIT_LOCK;
                     to_cnt_q  <= '0;
                     stb_cnt_q <= '0;
                  end else begin
                     rst_cnt_q <= rst_cnt_q - RC_W'(1);
                  end
               end
               ST_WAIT_LOCK: begin
                  to_cnt_q  <= to_cnt_q + TO_W'(1);
                  stb_cnt_q <= lock_s ? stb_cnt_q + ST_W'(1) : '0;
                  if (lock_s && (stb_cnt_q == ST_LAST)) begin
                     state_q  <= ST_LOCKED;
                     locked_q <= 1'b1;
                  end else if (to_cnt_q == TO_LAST) begin
                     state_q  <= ST_ERROR;
                     error_q  <= 1'b1;
                     arst_n_q <= 1'b0;
                  end
               end
               ST_LOCKED: begin
                  if (!lock_s) begin
                     lost_q    <= 1'b1;
                     locked_q  <= 1'b0;
                     state_q   <= ST_WAIT_LOCK;
                     to_cnt_q  <= '0;
                     stb_cnt_q <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pll_cfg_seq.sv
// tb/tb_pll_cfg_seq.sv - scoreboard bench for pll_cfg_seq with an event-level timing model
module tb_pll_cfg_seq;
   localparam int RST_C = 16;
   localparam int LS    = 8;
   localparam int LT    = 200;

   logic       clk = 1'b0;
   logic       rst_i = 1'b1;
   logic       req_valid_i = 1'b0;
   logic       req_ready_o;
   logic [3:0] req_refdiv_i = '0;
   logic [7:0] req_fbdiv_i = '0;
   logic       pll_arst_no;
   logic [3:0] pll_refdiv_o;
   logic [7:0] pll_fbdiv_o;
   logic       pll_locked_i = 1'b0;
   logic       busy_o, locked_o, lost_lock_o, error_o;

   pll_cfg_seq #(
      .REF_DEV_WIDTH(4), .FB_DIV_WIDTH(8),
      .RST_CYCLES(RST_C), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_refdiv_i(req_refdiv_i), .req_fbdiv_i(req_fbdiv_i),
      .pll_arst_no(pll_arst_no), .pll_refdiv_o(pll_refdiv_o), .pll_fbdiv_o(pll_fbdiv_o),
      .pll_locked_i(pll_locked_i), .busy_o(busy_o), .locked_o(locked_o),
      .lost_lock_o(lost_lock_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic       arst, locked, lost, err, busy;
      logic [3:0] rd;
      logic [7:0] fd;
   } snap_t;

   snap_t exp_q[$];
   snap_t last, mon_prev;
   int    checks = 0;
   int    errors = 0;
   bit    mon_en = 1'b0;
   bit    done = 1'b0;

   // Model: externally visible outputs; a snapshot is queued only when something changes.
   logic       m_arst = 0, m_locked = 0, m_lost = 0, m_err = 0, m_busy = 0;
   logic [3:0] m_rd = '0;
   logic [7:0] m_fd = '0;

   function automatic bit same(snap_t a, snap_t b);
      return a.arst === b.arst && a.locked === b.locked && a.lost === b.lost &&
             a.err === b.err && a.busy === b.busy && a.rd === b.rd && a.fd === b.fd;
   endfunction

   task automatic push(input int at);
      snap_t s;
      s.cyc = at; s.arst = m_arst; s.locked = m_locked; s.lost = m_lost;
      s.err = m_err; s.busy = m_busy; s.rd = m_rd; s.fd = m_fd;
      if (!same(s, last)) begin
         exp_q.push_back(s);
         last = s;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic model_accept(input logic [3:0] r, input logic [7:0] f, input int n, output int e);
      m_arst = 0; m_locked = 0; m_lost = 0; m_busy = 0;
      if (r == 0 || f == 0) begin
         m_err = 1;
         e = -1;
      end else begin
         m_err = 0; m_busy = 1; m_rd = r; m_fd = f;
         e = n + RST_C;
      end
      push(n);
   endtask

   task automatic issue(input logic [3:0] r, input logic [7:0] f, output int e);
      req_valid_i = 1; req_refdiv_i = r; req_fbdiv_i = f; pll_locked_i = 0;
      model_accept(r, f, cyc + 1, e);
      @(negedge clk);
      req_valid_i = 0;
   endtask

   // d<0: PLL never locks; h>0: lock high h cycles, low one cycle, then high again.
   task automatic lock_phase(input int e, input int d, input int h, output bit ok);
      int k, start, lock_at, to_at;
      to_at = e + LT;
      k = e + d;
      start = (h > 0) ? k + h + 1 : k;
      lock_at = start + LS + 2;
      ok = (d >= 0) && (lock_at <= to_at);
      m_arst = 1;
      push(e);
      if (ok) begin m_locked = 1; m_busy = 0; push(lock_at); end
      else begin m_err = 1; m_arst = 0; m_busy = 0; push(to_at); end
      if (d >= 0) begin
         wait_cyc(k); pll_locked_i = 1;
         if (h > 0) begin
            wait_cyc(k + h); pll_locked_i = 0;
            wait_cyc(k + h + 1); pll_locked_i = 1;
         end
      end
      wait_cyc(ok ? lock_at : to_at);
   endtask

   task automatic lost(input int g);
      int k;
      k = cyc;
      pll_locked_i = 0;
      m_lost = 1; m_locked = 0; m_busy = 1; push(k + 3);
      m_lost = 0; push(k + 4);
      m_locked = 1; m_busy = 0; push(k + g + LS + 2);
      wait_cyc(k + g); pll_locked_i = 1;
      wait_cyc(k + g + LS + 2);
   endtask

   task automatic reset_mid(input int e, input int t);
      if (t >= e) begin m_arst = 1; push(e); end
      wait_cyc(t);
      rst_i = 1;
      m_arst = 0; m_locked = 0; m_lost = 0; m_err = 0; m_busy = 0; m_rd = '0; m_fd = '0;
      push(t + 1);
      @(negedge clk);
      rst_i = 0;
   endtask

   always @(negedge clk) begin : monitor
      snap_t a, e;
      if (mon_en) begin
         a.cyc = cyc; a.arst = pll_arst_no; a.locked = locked_o; a.lost = lost_lock_o;
         a.err = error_o; a.busy = busy_o; a.rd = pll_refdiv_o; a.fd = pll_fbdiv_o;
         if (!same(a, mon_prev)) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: cyc=%0d arst=%b lk=%b lost=%b err=%b busy=%b div=%0d/%0d required no change",
                        a.cyc, a.arst, a.locked, a.lost, a.err, a.busy, a.rd, a.fd);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != a.cyc || !same(a, e) || req_ready_o !== !e.busy) begin
                  errors++;
                  $display("FAIL event: got cyc=%0d arst=%b lk=%b lost=%b err=%b busy=%b rdy=%b div=%0d/%0d required cyc=%0d arst=%b lk=%b lost=%b err=%b busy=%b rdy=%b div=%0d/%0d",
                           a.cyc, a.arst, a.locked, a.lost, a.err, a.busy, req_ready_o, a.rd, a.fd,
                           e.cyc, e.arst, e.locked, e.lost, e.err, e.busy, !e.busy, e.rd, e.fd);
               end
            end
            mon_prev = a;
         end
      end
   end

   initial begin : watchdog
      repeat (60000) @(posedge clk);
      if (!done) begin
         checks++; errors++;
         $display("FAIL watchdog: got cyc=%0d required completion", cyc);
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   initial begin : stim
      int  e, e2;
      bit  ok, locked;
      logic [3:0] r;
      logic [7:0] f;
      last = '{0, 0, 0, 0, 0, 0, 4'd0, 8'd0};
      mon_prev = last;
      repeat (3) @(negedge clk);
      chk("rst_arst_n", pll_arst_no, 0);
      chk("rst_refdiv", pll_refdiv_o, 0);
      chk("rst_fbdiv", pll_fbdiv_o, 0);
      chk("rst_locked", locked_o, 0);
      chk("rst_lost", lost_lock_o, 0);
      chk("rst_error", error_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ready", req_ready_o, 1);
      rst_i = 0;
      mon_en = 1;
      @(negedge clk);

      issue(4'd8, 8'd16, e);      lock_phase(e, 50, 0, ok);
      issue(4'd8, 8'd0, e);       repeat (3) @(negedge clk);
      issue(4'd1, 8'd128, e);     lock_phase(e, 20, 0, ok);
      issue(4'd3, 8'd7, e);       lock_phase(e, -1, 0, ok);
      issue(4'd2, 8'd9, e);       lock_phase(e, 10, 5, ok);
      lost(1);
      issue(4'd4, 8'd33, e);
      req_valid_i = 1; req_refdiv_i = 4'd5; req_fbdiv_i = 8'd66;
      lock_phase(e, 30, 0, ok);
      model_accept(4'd5, 8'd66, cyc + 1, e2);
      pll_locked_i = 0;
      @(negedge clk);
      req_valid_i = 0;
      lock_phase(e2, 0, 0, ok);
      issue(4'd1, 8'd1, e);       lock_phase(e, LT - LS - 2, 0, ok);
      issue(4'd15, 8'd255, e);    lock_phase(e, LT - LS - 1, 0, ok);
      issue(4'd6, 8'd6, e);       reset_mid(e, e + 5);
      issue(4'd7, 8'd70, e);      lock_phase(e, 5, 0, ok);
      pll_locked_i = 0;
      wait_cyc(cyc + 2);
      issue(4'd9, 8'd90, e);      lock_phase(e, 3, 0, ok);

      locked = ok;
      for (int it = 0; it < 25; it++) begin
         r = 4'($urandom_range(0, 15));
         f = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) != 0) begin
            if (r == 0) r = 4'd1;
            if (f == 0) f = 8'd1;
         end
         if (locked && $urandom_range(0, 3) == 0) begin
            pll_locked_i = 0;
            wait_cyc(cyc + 2);
         end
         issue(r, f, e);
         locked = 0;
         if (e < 0) continue;
         if ($urandom_range(0, 7) == 0) begin
            reset_mid(e, cyc + $urandom_range(0, 60));
            continue;
         end
         lock_phase(e, $urandom_range(0, 195), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0, ok);
         locked = ok;
         if (ok && $urandom_range(0, 1) == 1) lost($urandom_range(1, 4));
      end

      repeat (20) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_events: got %0d outstanding required 0", exp_q.size());
      end
      done = 1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
